// File: rtl/serial_compare_ctrl.sv
// Bit-serial magnitude comparator: one shared 1-bit compare cell is walked MSB-first
// over captured operands, stopping at the first differing bit.

module comparator_1bit (
    input  logic a,
    input  logic b,
    output logic eq,
    output logic gt,
    output logic lt
);
    assign eq = ~(a ^ b);
    assign gt = a & ~b;
    assign lt = ~a & b;
endmodule

module serial_compare_ctrl #(
    parameter  int WIDTH = 8,
    localparam int CW    = $clog2(WIDTH) + 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic             eq,
    output logic             gt,
    output logic             lt,
    output logic [CW-1:0]    steps
);
    localparam int IW = $clog2(WIDTH);

    generate
        if (WIDTH < 2 || WIDTH > 32) begin : g_bad_width
            $error("serial_compare_ctrl: WIDTH must be in 2..32");
        end
    endgenerate

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SCAN = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [WIDTH-1:0]   a_q, a_d;
    logic [WIDTH-1:0]   b_q, b_d;
    logic [CW-1:0]      idx_q, idx_d;
    logic [CW-1:0]      steps_q, steps_d;
    logic               eq_q, eq_d;
    logic               gt_q, gt_d;
    logic               lt_q, lt_d;

    logic               bit_a, bit_b;
    logic               cmp_eq, cmp_gt, cmp_lt;
    logic               accept;
    logic               last_bit;

    // idx never exceeds WIDTH-1, so the low IW bits address every operand bit.
    assign bit_a    = a_q[idx_q[IW-1:0]];
    assign bit_b    = b_q[idx_q[IW-1:0]];
    assign last_bit = (idx_q == '0);

    comparator_1bit u_cmp (
        .a  (bit_a),
        .b  (bit_b),
        .eq (cmp_eq),
        .gt (cmp_gt),
        .lt (cmp_lt)
    );

    // start is only honoured outside SCAN; DONE accepting it gives back-to-back ops.
    assign accept = start && (state_q != SCAN);

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (start) state_d = SCAN;
            end
            SCAN: begin
                if (cmp_gt || cmp_lt || (cmp_eq && last_bit)) state_d = DONE;
            end
            DONE: begin
                state_d = start ? SCAN : IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Output logic
    always_comb begin
        busy = 1'b0;
        done = 1'b0;
        case (state_q)
            SCAN:    busy = 1'b1;
            DONE:    done = 1'b1;
            default: ;
        endcase
    end

    always_comb begin
        a_d     = a_q;
        b_d     = b_q;
        idx_d   = idx_q;
        steps_d = steps_q;
        eq_d    = eq_q;
        gt_d    = gt_q;
        lt_d    = lt_q;
        if (accept) begin
            a_d     = a;
            b_d     = b;
            idx_d   = CW'(WIDTH - 1);
            steps_d = '0;
            eq_d    = 1'b0;
            gt_d    = 1'b0;
            lt_d    = 1'b0;
        end else if (state_q == SCAN) begin
            steps_d = steps_q + CW'(1);
            if (cmp_gt) begin
                gt_d = 1'b1;
            end else if (cmp_lt) begin
                lt_d = 1'b1;
            end else if (last_bit) begin
                eq_d = 1'b1;
            end else begin
                idx_d = idx_q - CW'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_q     <= '0;
            b_q     <= '0;
            idx_q   <= '0;
            steps_q <= '0;
            eq_q    <= 1'b0;
            gt_q    <= 1'b0;
            lt_q    <= 1'b0;
        end else begin
            a_q     <= a_d;
            b_q     <= b_d;
            idx_q   <= idx_d;
            steps_q <= steps_d;
            eq_q    <= eq_d;
            gt_q    <= gt_d;
            lt_q    <= lt_d;
        end
    end

    assign eq    = eq_q;
    assign gt    = gt_q;
    assign lt    = lt_q;
    assign steps = steps_q;

endmodule

// File: tb/tb_serial_compare_ctrl.sv
// Randomized self-checking bench for serial_compare_ctrl against an arithmetic reference model.

module tb_serial_compare_ctrl;
    localparam int W  = 8;
    localparam int CW = $clog2(W) + 1;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          start = 1'b0;
    logic [W-1:0]  a = '0;
    logic [W-1:0]  b = '0;
    logic          busy, done, eq, gt, lt;
    logic [CW-1:0] steps;

    int errs = 0;
    int nchk = 0;

    logic [2:0]    exp_res;
    int            exp_steps;

    serial_compare_ctrl #(.WIDTH(W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
        .a     (a),
        .b     (b),
        .busy  (busy),
        .done  (done),
        .eq    (eq),
        .gt    (gt),
        .lt    (lt),
        .steps (steps)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        nchk++;
        if (got !== exp) begin
            errs++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference: number of steps is the count of bits from the MSB down to the
    // highest differing bit, or W when the operands match.
    task automatic ref_model(input logic [W-1:0] ra, input logic [W-1:0] rb);
        logic [W-1:0] x;
        int p;
        x = ra ^ rb;
        p = -1;
        for (int i = 0; i < W; i++) if (x[i]) p = i;
        exp_steps = (p < 0) ? W : (W - p);
        exp_res   = {ra == rb, ra > rb, ra < rb};
    endtask

    // Called at a negedge; issues start and runs until the DONE-cycle negedge.
    task automatic op(input logic [W-1:0] ia, input logic [W-1:0] ib,
                      input bit hold, input logic [W-1:0] ha, input logic [W-1:0] hb);
        bit seen;
        int lat;
        ref_model(ia, ib);
        start = 1'b1;
        a = ia;
        b = ib;
        @(negedge clk);
        seen = 1'b0;
        lat  = 0;
        for (int c = 1; c <= W + 3 && !seen; c++) begin
            if (done) begin
                seen = 1'b1;
                lat  = c;
            end else begin
                chk("scan_busy", 32'(busy), 32'd1);
                chk("scan_res_clear", 32'({eq, gt, lt}), 32'd0);
                start = hold;
                a     = ha;
                b     = hb;
                @(negedge clk);
            end
        end
        chk("done_seen", 32'(seen), 32'd1);
        if (seen) begin
            chk("latency", 32'(lat), 32'(exp_steps + 1));
            chk("result", 32'({eq, gt, lt}), 32'(exp_res));
            chk("steps", 32'(steps), 32'(exp_steps));
            chk("done_busy", 32'(busy), 32'd0);
        end
    endtask

    task automatic idle(input int n);
        start = 1'b0;
        for (int i = 0; i < n; i++) begin
            a = W'($urandom);
            b = W'($urandom);
            @(negedge clk);
            chk("idle_busy", 32'(busy), 32'd0);
            chk("idle_done", 32'(done), 32'd0);
            chk("hold_res", 32'({eq, gt, lt}), 32'(exp_res));
            chk("hold_steps", 32'(steps), 32'(exp_steps));
        end
    endtask

    initial begin
        logic [W-1:0] ra, rb;
        int mode;

        #1;
        chk("rst_outputs", 32'({busy, done, eq, gt, lt, steps}), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("post_rst_idle", 32'({busy, done, eq, gt, lt, steps}), 32'd0);

        op(8'hA5, 8'h25, 1'b0, 8'h00, 8'h00);
        idle(2);
        op(8'h3C, 8'h3C, 1'b0, 8'h00, 8'h00);
        idle(2);
        op(8'h10, 8'h11, 1'b0, 8'h00, 8'h00);
        idle(5);
        op(8'h40, 8'h80, 1'b1, 8'hFF, 8'h00);
        idle(2);

        // Back-to-back: the second start lands in the first op's DONE cycle.
        op(8'h01, 8'h02, 1'b0, 8'h00, 8'h00);
        op(8'h02, 8'h01, 1'b0, 8'h00, 8'h00);
        idle(2);

        // Reset in the 4th SCAN cycle of a full-length compare.
        start = 1'b1;
        a = 8'h00;
        b = 8'h01;
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(negedge clk);
        chk("pre_abort_busy", 32'(busy), 32'd1);
        rst_n = 1'b0;
        #1;
        chk("abort_outputs", 32'({busy, done, eq, gt, lt, steps}), 32'd0);
        repeat (2) begin
            @(negedge clk);
            chk("abort_hold", 32'({busy, done, eq, gt, lt, steps}), 32'd0);
        end
        rst_n = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            chk("no_stale_done", 32'({busy, done}), 32'd0);
        end
        op(8'hFF, 8'hFE, 1'b0, 8'h00, 8'h00);
        idle(1);

        // Randomized operands, biased towards equal and single-bit-differing pairs.
        for (int n = 0; n < 60; n++) begin
            mode = int'($urandom_range(0, 3));
            ra = W'($urandom);
            case (mode)
                1:       rb = ra;
                2:       rb = ra ^ W'(1 << $urandom_range(0, W - 1));
                default: rb = W'($urandom);
            endcase
            op(ra, rb, $urandom_range(0, 1) == 1, W'($urandom), W'($urandom));
            if ($urandom_range(0, 2) != 0) idle(int'($urandom_range(1, 3)));
        end
        idle(1);

        // Reset landing in a DONE cycle drops done and the result.
        op(8'h80, 8'h00, 1'b0, 8'h00, 8'h00);
        rst_n = 1'b0;
        #1;
        chk("done_abort", 32'({busy, done, eq, gt, lt, steps}), 32'd0);
        start = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        $display("Result: errors=%0d of %0d checks", errs, nchk);
        $finish;
    end
endmodule
